vga_stream_timing: RTL and testbench

Parametrised VGA timing generator with a buffered pixel-stream input, successor to the fixed-mode `ice40_vga_driver`. It generates H/V sync and data-enable for any resolution set by parameters. During the active region it pops RGB pixels from an internal FIFO fed by a valid/ready upstream. It sits between the frame source (renderer or test logic) and the board VGA pins.

---
 rtl/vga_stream_timing.sv | 149 ++++++++++++++
 tb/tb_vga_stream_timing.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_timing.sv
`default_nettype none
// ============================================================================
// vga_stream_timing: parametrised VGA timing generator that pops RGB pixels
// from a valid/ready-fed FIFO. Optional colour bars: VGA_TEST_PATTERN_EN. Rev 1.0
// ============================================================================
module vga_stream_timing #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit HS_POL     = 1'b0,
   parameter bit VS_POL     = 1'b0,
   parameter int COLOR_W    = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3*COLOR_W-1:0] i_pix_data,
   input  logic                 i_pix_valid,
   output logic                 o_pix_ready,
   input  logic                 i_pat_en,
   input  logic                 i_underflow_clr,
   output logic                 o_h_sync,
   output logic                 o_v_sync,
   output logic                 o_de,
   output logic [COLOR_W-1:0]   o_r,
   output logic [COLOR_W-1:0]   o_g,
   output logic [COLOR_W-1:0]   o_b,
   output logic                 o_frame_start,
   output logic                 o_underflow
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int PIX_W   = 3 * COLOR_W;
   localparam int AW      = $clog2(FIFO_DEPTH);

   logic [HW-1:0]    h_cnt;
   logic [VW-1:0]    v_cnt;
   logic             h_last, v_last, active, hs_on, vs_on;
   logic [PIX_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             empty, full, push, pop, pat_on, uf_evt;
   logic [PIX_W-1:0] head, pat_pix, pix_q;

   assign h_last = (int'(h_cnt) == H_TOTAL - 1);
   assign v_last = (int'(v_cnt) == V_TOTAL - 1);
   assign active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
   assign hs_on  = (int'(h_cnt) >= H_ACTIVE + H_FP) &&
                   (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
   assign vs_on  = (int'(v_cnt) >= V_ACTIVE + V_FP) &&
                   (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign o_pix_ready = ~full;
   assign push        = i_pix_valid && ~full;
   assign pop         = active && ~empty && ~pat_on;
   assign uf_evt      = active && empty && ~pat_on;
   assign head        = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= i_pix_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   int         bar_idx;
   logic [2:0] bar;

   always_comb begin
      bar_idx = int'(h_cnt) / BAR_W;
      bar     = (bar_idx > 7) ? 3'd7 : bar_idx[2:0];
   end

   assign pat_on  = i_pat_en;
   assign pat_pix = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
`else
   logic unused_pat_en;
   assign unused_pat_en = i_pat_en;
   assign pat_on        = 1'b0;
   assign pat_pix       = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_h_sync      <= ~HS_POL;
         o_v_sync      <= ~VS_POL;
         o_de          <= 1'b0;
         o_frame_start <= 1'b0;
         o_underflow   <= 1'b0;
         pix_q         <= '0;
      end else begin
         o_h_sync      <= hs_on ? HS_POL : ~HS_POL;
         o_v_sync      <= vs_on ? VS_POL : ~VS_POL;
         o_de          <= active;
         o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
         if (active && pat_on) begin
            pix_q <= pat_pix;
         end else if (pop) begin
            pix_q <= head;
         end else begin
            pix_q <= '0;
         end
         // A new underflow outranks a clear arriving in the same cycle.
         if (uf_evt) begin
            o_underflow <= 1'b1;
         end else if (i_underflow_clr) begin
            o_underflow <= 1'b0;
         end
      end
   end

   assign o_r = pix_q[PIX_W-1 -: COLOR_W];
   assign o_g = pix_q[2*COLOR_W-1 -: COLOR_W];
   assign o_b = pix_q[COLOR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_stream_timing.sv
`default_nettype none
// tb_vga_stream_timing: randomized checks of vga_stream_timing in a small video
// mode against a frame-position and pixel-queue reference model.
module tb_vga_stream_timing;
   localparam int H_A = 8, H_F = 2, H_S = 2, H_B = 2;
   localparam int V_A = 4, V_F = 1, V_S = 1, V_B = 1;
   localparam int HT    = H_A + H_F + H_S + H_B;
   localparam int VT    = V_A + V_F + V_S + V_B;
   localparam int FRAME = HT * VT;
   localparam int DEPTH = 4;
   localparam int CW    = 4;
   // {h_sync, v_sync, de, frame_start, underflow, pix_ready, r, g, b}
   localparam logic [17:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic [11:0]   pix_data  = '0;
   logic          pix_valid = 1'b0;
   logic          pat_en    = 1'b0;
   logic          uf_clr    = 1'b0;
   logic          pix_ready, h_sync, v_sync, de, frame_start, underflow;
   logic [CW-1:0] r, g, b;
   int            total = 0;
   int            bad   = 0;

   vga_stream_timing #(
      .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
      .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .i_pix_data(pix_data), .i_pix_valid(pix_valid), .o_pix_ready(pix_ready),
      .i_pat_en(pat_en), .i_underflow_clr(uf_clr),
      .o_h_sync(h_sync), .o_v_sync(v_sync), .o_de(de),
      .o_r(r), .o_g(g), .o_b(b),
      .o_frame_start(frame_start), .o_underflow(underflow)
   );

   always #5 clk = ~clk;

   wire [17:0] dut_vec = {h_sync, v_sync, de, frame_start, underflow, pix_ready, r, g, b};

   // Reference model: position in frame as a single cycle index, FIFO as a queue.
   int          cnt;
   logic [11:0] q[$];
   logic        m_uf;
   logic [17:0] exp_vec;
   int          mh, mv, m_bar;
   logic        m_act, m_pat, m_rdy, m_ufe;
   logic [11:0] m_pix;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt = 0;
         q.delete();
         m_uf = 1'b0;
         exp_vec = RESET_VEC;
      end else begin
         mh    = cnt % HT;
         mv    = cnt / HT;
         m_act = (mh < H_A) && (mv < V_A);
`ifdef VGA_TEST_PATTERN_EN
         m_pat = pat_en;
`else
         m_pat = 1'b0;
`endif
         m_rdy = (q.size() < DEPTH);
         m_ufe = 1'b0;
         m_pix = '0;
         if (m_act && m_pat) begin
            m_bar = mh / (H_A / 8);
            m_pix = {m_bar[2] ? 4'hF : 4'h0, m_bar[1] ? 4'hF : 4'h0, m_bar[0] ? 4'hF : 4'h0};
         end else if (m_act) begin
            if (q.size() > 0) m_pix = q.pop_front();
            else              m_ufe = 1'b1;
         end
         if (pix_valid && m_rdy) q.push_back(pix_data);
         if (m_ufe)       m_uf = 1'b1;
         else if (uf_clr) m_uf = 1'b0;
         exp_vec = {!(mh >= H_A + H_F && mh < H_A + H_F + H_S),
                    !(mv >= V_A + V_F && mv < V_A + V_F + V_S),
                    m_act, (cnt == 0), m_uf, (q.size() < DEPTH), m_pix};
         cnt = (cnt + 1) % FRAME;
      end
   end

   task automatic test_reset();
      reset = 1'b1; pix_valid = 1'b0; uf_clr = 1'b0; pat_en = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (dut_vec !== RESET_VEC) begin
         bad++; $display("FAIL reset_values got=%h exp=%h", dut_vec, RESET_VEC);
      end
   endtask

   task automatic test_timing();
      int hs_low = 0, vs_low = 0, de_hi = 0, fs_n = 0;
      reset = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL timing t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
         hs_low += (h_sync === 1'b0) ? 1 : 0;
         vs_low += (v_sync === 1'b0) ? 1 : 0;
         de_hi  += (de === 1'b1) ? 1 : 0;
         fs_n   += (frame_start === 1'b1) ? 1 : 0;
      end
      total++;
      if (hs_low != 2 * VT * H_S) begin bad++; $display("FAIL hsync_count got=%0d exp=%0d", hs_low, 2 * VT * H_S); end
      total++;
      if (vs_low != 2 * V_S * HT) begin bad++; $display("FAIL vsync_count got=%0d exp=%0d", vs_low, 2 * V_S * HT); end
      total++;
      if (de_hi != 2 * H_A * V_A) begin bad++; $display("FAIL de_count got=%0d exp=%0d", de_hi, 2 * H_A * V_A); end
      total++;
      if (fs_n != 2) begin bad++; $display("FAIL frame_start_count got=%0d exp=2", fs_n); end
   endtask

   task automatic test_stream();
      bit found = 1'b0;
      pix_valid = 1'b1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL stream_fill t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
         pix_data = 12'($urandom);
         if (cnt / HT >= V_A && q.size() == DEPTH) begin found = 1'b1; break; end
      end
      total++;
      if (!found) begin bad++; $display("FAIL stream_fill_wait got=timeout exp=full_in_blanking"); end
      uf_clr = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL stream t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
         uf_clr   = 1'b0;
         pix_data = 12'($urandom);
      end
      total++;
      if (underflow !== 1'b0) begin bad++; $display("FAIL stream_no_underflow got=%b exp=0", underflow); end
   endtask

   task automatic test_underflow();
      bit found = 1'b0;
      int sent = 0, act_n = 0;
      pix_valid = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL uf_drain t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
         if (q.size() == 0 && cnt == V_A * HT) begin found = 1'b1; break; end
      end
      total++;
      if (!found) begin bad++; $display("FAIL uf_drain_wait got=timeout exp=empty_at_vblank"); end
      uf_clr = 1'b1;
      @(negedge clk);
      uf_clr = 1'b0;
      total++;
      if (underflow !== 1'b0) begin bad++; $display("FAIL uf_cleared got=%b exp=0", underflow); end
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         pix_valid = (sent < 5);
         pix_data  = 12'($urandom);
         if (pix_valid && pix_ready) sent++;
         @(negedge clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL uf_stream t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
         if (de) begin
            act_n++;
            if (act_n == 5) begin
               total++;
               if (underflow !== 1'b0) begin bad++; $display("FAIL uf_fifth got=%b exp=0", underflow); end
            end
            if (act_n == 6) begin
               total++;
               if (underflow !== 1'b1) begin bad++; $display("FAIL uf_sixth got=%b exp=1", underflow); end
            end
            if (act_n == H_A) begin found = 1'b1; break; end
         end
      end
      total++;
      if (!found) begin bad++; $display("FAIL uf_line_wait got=timeout exp=active_line"); end
      pix_valid = 1'b0;
      uf_clr = 1'b1;
      @(negedge clk);
      uf_clr = 1'b0;
      total++;
      if (underflow !== 1'b0) begin bad++; $display("FAIL uf_clear_blank got=%b exp=0", underflow); end
   endtask

   task automatic test_backpressure();
      bit found = 1'b0;
      pix_valid = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL bp_wait t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
         if (q.size() == 0 && cnt == V_A * HT) begin found = 1'b1; break; end
      end
      total++;
      if (!found) begin bad++; $display("FAIL bp_wait_pos got=timeout exp=vblank"); end
      found = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         pix_valid = 1'b1;
         pix_data  = 12'($urandom);
         @(negedge clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL bp t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
         if (i == 10) begin
            total++;
            if (pix_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", pix_ready); end
         end
         if (frame_start) begin
            total++;
            if (pix_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rise got=%b exp=1", pix_ready); end
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found) begin bad++; $display("FAIL bp_frame_wait got=timeout exp=frame_start"); end
      for (int i = 0; i < HT; i++) begin
         pix_data = 12'($urandom);
         @(negedge clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL bp_line t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      int fs_n = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         pix_valid = 1'($urandom % 2);
         pix_data  = 12'($urandom);
         @(negedge clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL rm_wait t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
         if (cnt == HT + 4) begin found = 1'b1; break; end
      end
      total++;
      if (!found) begin bad++; $display("FAIL rm_wait_pos got=timeout exp=mid_line"); end
      reset = 1'b1;
      #1;
      total++;
      if (dut_vec !== RESET_VEC) begin bad++; $display("FAIL rst_async got=%h exp=%h", dut_vec, RESET_VEC); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (dut_vec !== RESET_VEC) begin bad++; $display("FAIL rst_hold got=%h exp=%h", dut_vec, RESET_VEC); end
      end
      reset = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         pix_valid = 1'($urandom % 2);
         pix_data  = 12'($urandom);
         @(negedge clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL rst_run t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
         if (i == 0) begin
            total++;
            if (frame_start !== 1'b1) begin bad++; $display("FAIL rst_fs_first got=%b exp=1", frame_start); end
         end
         fs_n += (frame_start === 1'b1) ? 1 : 0;
      end
      total++;
      if (fs_n != 1) begin bad++; $display("FAIL rst_fs_once got=%0d exp=1", fs_n); end
   endtask

`ifdef VGA_TEST_PATTERN_EN
   task automatic test_pattern();
      bit found = 1'b0;
      int k = -1;
      pat_en    = 1'b1;
      pix_valid = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         pix_data = 12'($urandom);
         @(negedge clk);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL pat_wait t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
         if (cnt == V_A * HT) begin found = 1'b1; break; end
      end
      total++;
      if (!found) begin bad++; $display("FAIL pat_wait_pos got=timeout exp=vblank"); end
      uf_clr = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         uf_clr   = 1'b0;
         pix_data = 12'($urandom);
         total++;
         if (dut_vec !== exp_vec) begin
            bad++; $display("FAIL pat t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
         end
         if (frame_start) k = 0;
         else if (k >= 0) k++;
         if (k == 0) begin
            total++;
            if ({r, g, b} !== 12'h000) begin bad++; $display("FAIL pat_bar0 got=%h exp=000", {r, g, b}); end
         end
         if (k == 5) begin
            total++;
            if ({r, g, b} !== 12'hF0F) begin bad++; $display("FAIL pat_bar5 got=%h exp=f0f", {r, g, b}); end
         end
      end
      total++;
      if (underflow !== 1'b0) begin bad++; $display("FAIL pat_no_underflow got=%b exp=0", underflow); end
      total++;
      if (pix_ready !== 1'b0) begin bad++; $display("FAIL pat_fifo_held got=%b exp=0", pix_ready); end
      pat_en    = 1'b0;
      pix_valid = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_timing();
      test_stream();
      test_underflow();
      test_backpressure();
      test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
